// File: rtl/charset_loader_pkg.sv
// Shared types and constants for the charset loader.
// S_CSUM is only present when CHARSET_CSUM_EN is defined.
package charset_loader_pkg;

  localparam int LEN_W = 9;
  localparam logic [LEN_W-1:0] LEN_ZERO_IS_256 = 9'd256;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
`ifdef CHARSET_CSUM_EN
    S_CSUM = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  // A length byte of zero stands for a full 256-entry charset.
  function automatic logic [LEN_W-1:0] decode_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? LEN_ZERO_IS_256 : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/charset_timeout.sv
// Idle-cycle counter for the charset loader; expired pulses on the cycle
// that would complete TIMEOUT consecutive enabled cycles.
module charset_timeout #(
  parameter int TIMEOUT = 1048575
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/charset_loader.sv
// Frame parser that loads a character map from a host byte stream.
// Define CHARSET_CSUM_EN to require a trailing XOR check byte per frame.
module charset_loader
  import charset_loader_pkg::*;
#(
  parameter int TIMEOUT = 1048575
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_enable,
  output logic [7:0]       char_pos_wr,
  output logic [7:0]       char_val_wr,
  output logic [LEN_W-1:0] charset_len,
  output logic             load_done,
  output logic             load_err
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] charset_len_q, charset_len_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       pos_q, pos_d;
  logic [7:0]       val_q, val_d;
`ifdef CHARSET_CSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic accept;
  logic counting;
  logic tmo_enable;
  logic tmo_expired;

  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid && in_ready;

`ifdef CHARSET_CSUM_EN
  assign counting = (state_q == S_DATA) || (state_q == S_CSUM);
`else
  assign counting = (state_q == S_DATA);
`endif
  assign tmo_enable = counting && !accept;

  charset_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!tmo_enable),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    charset_len_d = charset_len_q;
    done_d        = done_q;
    err_d         = err_q;
    wr_en_d       = 1'b0;
    pos_d         = pos_q;
    val_d         = val_q;
`ifdef CHARSET_CSUM_EN
    csum_d        = csum_q;
`endif
    case (state_q)
      S_LEN: begin
        if (accept) begin
          len_d   = decode_len(in_data);
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef CHARSET_CSUM_EN
          csum_d  = in_data;
`endif
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          wr_en_d = 1'b1;
          pos_d   = idx_q[7:0];
          val_d   = in_data;
          idx_d   = idx_q + 9'd1;
`ifdef CHARSET_CSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          if ((idx_q + 9'd1) == len_q) begin
`ifdef CHARSET_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = S_LEN;
        end
      end
`ifdef CHARSET_CSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_LEN;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = S_LEN;
        end
      end
`endif
      S_DONE: begin
        charset_len_d = len_q;
        done_d        = 1'b1;
        state_d       = S_LEN;
      end
      default: state_d = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LEN;
      idx_q         <= '0;
      len_q         <= '0;
      charset_len_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      pos_q         <= '0;
      val_q         <= '0;
`ifdef CHARSET_CSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      charset_len_q <= charset_len_d;
      done_q        <= done_d;
      err_q         <= err_d;
      wr_en_q       <= wr_en_d;
      pos_q         <= pos_d;
      val_q         <= val_d;
`ifdef CHARSET_CSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign wr_enable   = wr_en_q;
  assign char_pos_wr = pos_q;
  assign char_val_wr = val_q;
  assign charset_len = charset_len_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

endmodule
